pwm_dutycycle_configurator: RTL and testbench

- Upstream configuration stage for the half-bridge PWM block. Converts a normalised duty-cycle request plus period and deadtimes into the tick counts the PWM consumes.
- Drives the PWM's `tick_count_period`, `tick_count_highside`, `tick_count_lowside`, `deadtime_hs_to_ls`, `deadtime_ls_to_hs` and `configuration_load_enable` inputs.
- Uses a valid/ready request handshake and a serial shift-add multiplier, so no hardware multiplier is needed.

---
 rtl/pwm_dutycycle_configurator.sv | 174 +++++++++++++++++
 tb/tb_pwm_dutycycle_configurator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dutycycle_configurator.sv
// Converts a normalised duty request plus period/deadtimes into PWM tick counts.
// A serial shift-add multiplier scales the usable period, then the result is clamped so both pulses stay nonzero.
module pwm_dutycycle_configurator #(
   parameter int bitwidth      = 8,
   parameter int duty_bitwidth = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     request_valid,
   output logic                     request_ready,
   input  logic [duty_bitwidth-1:0] request_duty,
   input  logic [bitwidth-1:0]      request_period,
   input  logic [bitwidth-1:0]      request_deadtime_hs_to_ls,
   input  logic [bitwidth-1:0]      request_deadtime_ls_to_hs,
   output logic [bitwidth-1:0]      tick_count_period,
   output logic [bitwidth-1:0]      tick_count_highside,
   output logic [bitwidth-1:0]      tick_count_lowside,
   output logic [bitwidth-1:0]      deadtime_hs_to_ls,
   output logic [bitwidth-1:0]      deadtime_ls_to_hs,
   output logic                     configuration_load_enable,
   output logic                     busy,
   output logic                     configuration_error
);

   localparam int AccW = bitwidth + duty_bitwidth;
   localparam int CntW = (duty_bitwidth > 1) ? $clog2(duty_bitwidth) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StMultiply,
      StClamp,
      StLoad
   } state_t;

   state_t                   state_q;
   logic                     ready_q;
   logic                     busy_q;
   logic                     loadEnable_q;
   logic                     error_q;
   logic [bitwidth-1:0]      period_q;
   logic [bitwidth-1:0]      dtHsToLs_q;
   logic [bitwidth-1:0]      dtLsToHs_q;
   logic [bitwidth-1:0]      avail_q;
   logic [duty_bitwidth-1:0] dutyShift_q;
   logic [AccW-1:0]          mcand_q;
   logic [AccW-1:0]          acc_q;
   logic [CntW-1:0]          iter_q;
   logic [bitwidth-1:0]      tickPeriod_q;
   logic [bitwidth-1:0]      tickHs_q;
   logic [bitwidth-1:0]      tickLs_q;
   logic [bitwidth-1:0]      outDtHsToLs_q;
   logic [bitwidth-1:0]      outDtLsToHs_q;

   logic [bitwidth:0]        dtSum_d;
   logic [bitwidth-1:0]      avail_d;
   logic                     checkError_d;
   logic [AccW-1:0]          accStep_d;
   logic [bitwidth-1:0]      product_d;
   logic [bitwidth-1:0]      availMinus1_d;
   logic [bitwidth-1:0]      highside_d;
   logic [bitwidth-1:0]      lowside_d;

   always_comb begin
      dtSum_d       = {1'b0, dtHsToLs_q} + {1'b0, dtLsToHs_q};
      avail_d       = period_q - dtHsToLs_q - dtLsToHs_q;
      // Sum is widened by one more bit so the +2 margin cannot wrap.
      checkError_d  = (period_q == '0) ||
                      (({1'b0, dtSum_d} + (bitwidth+2)'(2)) > {2'b00, period_q});
      accStep_d     = dutyShift_q[0] ? (acc_q + mcand_q) : acc_q;
      product_d     = acc_q[AccW-1:duty_bitwidth];
      availMinus1_d = avail_q - bitwidth'(1);
      highside_d    = (product_d > availMinus1_d) ? availMinus1_d : product_d;
      if (highside_d == '0) begin
         highside_d = bitwidth'(1);
      end
      lowside_d     = avail_q - highside_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         ready_q       <= 1'b0;
         busy_q        <= 1'b0;
         loadEnable_q  <= 1'b0;
         error_q       <= 1'b0;
         period_q      <= '0;
         dtHsToLs_q    <= '0;
         dtLsToHs_q    <= '0;
         avail_q       <= '0;
         dutyShift_q   <= '0;
         mcand_q       <= '0;
         acc_q         <= '0;
         iter_q        <= '0;
         tickPeriod_q  <= '0;
         tickHs_q      <= '0;
         tickLs_q      <= '0;
         outDtHsToLs_q <= '0;
         outDtLsToHs_q <= '0;
      end else begin
         loadEnable_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ready_q && request_valid) begin
                  period_q    <= request_period;
                  dtHsToLs_q  <= request_deadtime_hs_to_ls;
                  dtLsToHs_q  <= request_deadtime_ls_to_hs;
                  dutyShift_q <= request_duty;
                  error_q     <= 1'b0;
                  ready_q     <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= StCheck;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            StCheck: begin
               if (checkError_d) begin
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  avail_q <= avail_d;
                  mcand_q <= AccW'(avail_d);
                  acc_q   <= '0;
                  iter_q  <= '0;
                  state_q <= StMultiply;
               end
            end
            StMultiply: begin
               // LSB-first: add the shifted multiplicand whenever the current duty bit is set.
               acc_q       <= accStep_d;
               mcand_q     <= mcand_q << 1;
               dutyShift_q <= dutyShift_q >> 1;
               if (iter_q == CntW'(duty_bitwidth - 1)) begin
                  iter_q  <= '0;
                  state_q <= StClamp;
               end else begin
                  iter_q <= iter_q + CntW'(1);
               end
            end
            StClamp: begin
               tickPeriod_q  <= period_q;
               tickHs_q      <= highside_d;
               tickLs_q      <= lowside_d;
               outDtHsToLs_q <= dtHsToLs_q;
               outDtLsToHs_q <= dtLsToHs_q;
               loadEnable_q  <= 1'b1;
               state_q       <= StLoad;
            end
            StLoad: begin
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign request_ready             = ready_q;
   assign busy                      = busy_q;
   assign configuration_load_enable = loadEnable_q;
   assign configuration_error       = error_q;
   assign tick_count_period         = tickPeriod_q;
   assign tick_count_highside       = tickHs_q;
   assign tick_count_lowside        = tickLs_q;
   assign deadtime_hs_to_ls         = outDtHsToLs_q;
   assign deadtime_ls_to_hs         = outDtLsToHs_q;

endmodule

// File: tb/tb_pwm_dutycycle_configurator.sv
// Bench for pwm_dutycycle_configurator: a cycle-timeline model of the request/load behaviour
// is compared against the DUT on every falling edge, plus directed literal checks.
module tb_pwm_dutycycle_configurator;

   localparam int BW = 8;
   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          request_valid = 1'b0;
   logic          request_ready;
   logic [DW-1:0] request_duty = '0;
   logic [BW-1:0] request_period = '0;
   logic [BW-1:0] request_deadtime_hs_to_ls = '0;
   logic [BW-1:0] request_deadtime_ls_to_hs = '0;
   logic [BW-1:0] tick_count_period;
   logic [BW-1:0] tick_count_highside;
   logic [BW-1:0] tick_count_lowside;
   logic [BW-1:0] deadtime_hs_to_ls;
   logic [BW-1:0] deadtime_ls_to_hs;
   logic          configuration_load_enable;
   logic          busy;
   logic          configuration_error;

   int testsRun = 0;
   int testsFailed = 0;
   int cycleNum = 0;

   pwm_dutycycle_configurator #(.bitwidth(BW), .duty_bitwidth(DW)) dut (
      .clock                     (clock),
      .reset_n                   (reset_n),
      .request_valid             (request_valid),
      .request_ready             (request_ready),
      .request_duty              (request_duty),
      .request_period            (request_period),
      .request_deadtime_hs_to_ls (request_deadtime_hs_to_ls),
      .request_deadtime_ls_to_hs (request_deadtime_ls_to_hs),
      .tick_count_period         (tick_count_period),
      .tick_count_highside       (tick_count_highside),
      .tick_count_lowside        (tick_count_lowside),
      .deadtime_hs_to_ls         (deadtime_hs_to_ls),
      .deadtime_ls_to_hs         (deadtime_ls_to_hs),
      .configuration_load_enable (configuration_load_enable),
      .busy                      (busy),
      .configuration_error       (configuration_error)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleNum, actual, expected);
      end
   endtask

   // Model: current visible outputs plus a countdown of edges since the last accepted request.
   int mReady = 0, mBusy = 0, mLoad = 0, mErr = 0;
   int mPeriod = 0, mHs = 0, mLs = 0, mDtHl = 0, mDtLh = 0;
   int active = 0, edgeCount = 0;
   int pErr = 0, pPeriod = 0, pHs = 0, pLs = 0, pDtHl = 0, pDtLh = 0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mReady = 0; mBusy = 0; mLoad = 0; mErr = 0;
         mPeriod = 0; mHs = 0; mLs = 0; mDtHl = 0; mDtLh = 0;
         active = 0; edgeCount = 0;
      end else if (active != 0) begin
         edgeCount++;
         if (pErr != 0 && edgeCount == 1) begin
            active = 0; mBusy = 0; mErr = 1;
         end else if (pErr == 0 && edgeCount == DW + 2) begin
            mPeriod = pPeriod; mHs = pHs; mLs = pLs; mDtHl = pDtHl; mDtLh = pDtLh;
            mLoad = 1;
         end else if (pErr == 0 && edgeCount == DW + 3) begin
            mLoad = 0; mBusy = 0; mReady = 1; active = 0;
         end
      end else if (mReady != 0 && request_valid) begin
         int avail;
         int prod;
         pPeriod = int'(request_period);
         pDtHl   = int'(request_deadtime_hs_to_ls);
         pDtLh   = int'(request_deadtime_ls_to_hs);
         avail   = pPeriod - pDtHl - pDtLh;
         pErr    = (pPeriod == 0 || avail < 2) ? 1 : 0;
         if (pErr == 0) begin
            prod = (avail * int'(request_duty)) / (1 << DW);
            pHs  = (prod > avail - 1) ? avail - 1 : prod;
            if (pHs < 1) pHs = 1;
            pLs  = avail - pHs;
         end
         active = 1; edgeCount = 0; mBusy = 1; mReady = 0; mErr = 0;
      end else begin
         mReady = 1;
      end
   end

   always @(negedge clock) begin
      cycleNum++;
      checkOutput("request_ready", int'(request_ready), mReady);
      checkOutput("busy", int'(busy), mBusy);
      checkOutput("load_enable", int'(configuration_load_enable), mLoad);
      checkOutput("config_error", int'(configuration_error), mErr);
      checkOutput("tick_period", int'(tick_count_period), mPeriod);
      checkOutput("tick_highside", int'(tick_count_highside), mHs);
      checkOutput("tick_lowside", int'(tick_count_lowside), mLs);
      checkOutput("dt_hs_to_ls", int'(deadtime_hs_to_ls), mDtHl);
      checkOutput("dt_ls_to_hs", int'(deadtime_ls_to_hs), mDtLh);
   end

   // Drives a request and returns just after the accepting rising edge (valid left high).
   task automatic applyStimulus(input int duty, input int period, input int dtHl, input int dtLh);
      int waitCycles = 0;
      @(negedge clock);
      #1;
      request_valid             = 1'b1;
      request_duty              = DW'(duty);
      request_period            = BW'(period);
      request_deadtime_hs_to_ls = BW'(dtHl);
      request_deadtime_ls_to_hs = BW'(dtLh);
      while (!request_ready && waitCycles < 60) begin
         @(negedge clock);
         #1;
         waitCycles++;
      end
      if (!request_ready) begin
         checkOutput("accept_timeout", int'(request_ready), 1);
         request_valid = 1'b0;
      end else begin
         @(posedge clock);
      end
   endtask

   // Counts falling edges until the load pulse is seen and checks that count.
   task automatic waitForLoad(input string name, input int expLatency);
      int cycles = 0;
      bit seen = 1'b0;
      while (!seen && cycles < 40) begin
         @(negedge clock);
         cycles++;
         if (configuration_load_enable) seen = 1'b1;
         #1 request_valid = 1'b0;
      end
      checkOutput(name, cycles, expLatency);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int loads;
      int stage;

      repeat (3) @(negedge clock);
      checkOutput("reset_ready", int'(request_ready), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_highside", int'(tick_count_highside), 0);
      checkOutput("reset_error", int'(configuration_error), 0);
      #1 reset_n = 1'b1;
      @(negedge clock);
      checkOutput("ready_after_reset", int'(request_ready), 1);

      // Mid-range duty
      applyStimulus(128, 100, 5, 5);
      waitForLoad("latency_duty128", 11);
      checkOutput("duty128_hs", int'(tick_count_highside), 45);
      checkOutput("duty128_ls", int'(tick_count_lowside), 45);
      checkOutput("duty128_period", int'(tick_count_period), 100);
      checkOutput("duty128_dt_hl", int'(deadtime_hs_to_ls), 5);
      checkOutput("duty128_dt_lh", int'(deadtime_ls_to_hs), 5);
      checkOutput("duty128_err", int'(configuration_error), 0);
      @(negedge clock);
      checkOutput("duty128_single_pulse", int'(configuration_load_enable), 0);

      // Clamp boundaries
      applyStimulus(0, 100, 5, 5);
      waitForLoad("latency_duty0", 11);
      checkOutput("duty0_hs", int'(tick_count_highside), 1);
      checkOutput("duty0_ls", int'(tick_count_lowside), 89);
      applyStimulus(255, 100, 5, 5);
      waitForLoad("latency_duty255", 11);
      checkOutput("duty255_hs", int'(tick_count_highside), 89);
      checkOutput("duty255_ls", int'(tick_count_lowside), 1);

      // Rejected requests: available < 2, then zero period
      for (int t = 0; t < 2; t++) begin
         if (t == 0) applyStimulus(128, 10, 5, 4);
         else        applyStimulus(128, 0, 0, 0);
         @(negedge clock);
         checkOutput("err_c1_busy", int'(busy), 1);
         checkOutput("err_c1_load", int'(configuration_load_enable), 0);
         @(negedge clock);
         checkOutput("err_c2_error", int'(configuration_error), 1);
         checkOutput("err_c2_ready", int'(request_ready), 0);
         checkOutput("err_c2_busy", int'(busy), 0);
         #1 request_valid = 1'b0;
         @(negedge clock);
         checkOutput("err_c3_ready", int'(request_ready), 1);
         checkOutput("err_c3_load", int'(configuration_load_enable), 0);
         checkOutput("err_c3_hs_held", int'(tick_count_highside), 89);
         checkOutput("err_c3_ls_held", int'(tick_count_lowside), 1);
      end

      // Good request after an error clears the flag on acceptance
      applyStimulus(128, 100, 5, 5);
      @(negedge clock);
      checkOutput("err_cleared_on_accept", int'(configuration_error), 0);
      #1 request_valid = 1'b0;
      waitForLoad("latency_after_error", 10);
      checkOutput("after_err_hs", int'(tick_count_highside), 45);
      checkOutput("after_err_ls", int'(tick_count_lowside), 45);

      // Valid held high with changing fields; second request B = duty 64, period 50, dts 2/3
      applyStimulus(128, 100, 5, 5);
      loads = 0;
      stage = 0;
      for (int k = 0; k < 60 && stage < 2; k++) begin
         @(negedge clock);
         if (configuration_load_enable) begin
            loads++;
            if (loads == 1) begin
               checkOutput("hold_first_hs", int'(tick_count_highside), 45);
               checkOutput("hold_first_ls", int'(tick_count_lowside), 45);
            end else begin
               checkOutput("hold_second_hs", int'(tick_count_highside), 11);
               checkOutput("hold_second_ls", int'(tick_count_lowside), 34);
               stage = 2;
            end
         end
         #1;
         if (stage == 0 && request_ready) begin
            request_duty              = 8'd64;
            request_period            = 8'd50;
            request_deadtime_hs_to_ls = 8'd2;
            request_deadtime_ls_to_hs = 8'd3;
            stage = 1;
         end else if (stage == 0) begin
            request_duty              = DW'(k * 37 + 11);
            request_period            = BW'(255 - k);
            request_deadtime_hs_to_ls = BW'(k);
            request_deadtime_ls_to_hs = BW'(k + 1);
         end else if (stage == 1 && !request_ready) begin
            request_valid = 1'b0;
         end
      end
      checkOutput("hold_load_count", loads, 2);

      // Reset during MULTIPLY aborts with everything cleared
      applyStimulus(200, 150, 10, 20);
      #1 request_valid = 1'b0;
      repeat (4) @(negedge clock);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("abort_load", int'(configuration_load_enable), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_ready", int'(request_ready), 0);
      checkOutput("abort_hs", int'(tick_count_highside), 0);
      checkOutput("abort_ls", int'(tick_count_lowside), 0);
      checkOutput("abort_period", int'(tick_count_period), 0);
      repeat (2) @(negedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      checkOutput("abort_ready_after_release", int'(request_ready), 1);
      applyStimulus(200, 150, 10, 20);
      waitForLoad("latency_after_abort", 11);
      checkOutput("after_abort_hs", int'(tick_count_highside), 93);
      checkOutput("after_abort_ls", int'(tick_count_lowside), 27);
      checkOutput("after_abort_period", int'(tick_count_period), 150);

      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
